mux4x2_arb: RTL and testbench
=============================

# mux4x2_arb

Allocation controller for the hring 4x2 crossbar mux. Each cycle it takes valid requests from four ring input ports and two local injection ports and produces the crossbar selects `sel0` and `sel1` plus per-requester grants. Ring traffic has priority and is shared round-robin; local injection has an optional starvation guard. It sits beside `mux4x2` in the ring node and drives its select inputs directly.

## Interface
Parameters:
- `STARVE_MAX`, default 7: consecutive denied cycles after which a local port reserves its output.
- `SCW`, default 3: starvation counter width; must hold `STARVE_MAX`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in 4: ring port 0..3 holds a valid flit (valid bit of `port*_ci`).
- `reql` in 2: local port l0/l1 has a flit to inject.
- `gnt` out 4: ring port i is routed this cycle.
- `gntl` out 2: local port li is routed this cycle.
- `stall` out 4: `req & ~gnt`; the ring port must hold its flit.
- `sel0` out 3: select for `port0_co`.
- `sel1` out 3: select for `port1_co`.

## Operation
- Select encoding, defined in `defines.v`:
  - `SEL_P0`..`SEL_P3` = 0..3 (ring port).
  - `SEL_LOC` = 4 (`portl0` on output 0, `portl1` on output 1).
  - `SEL_IDLE` = 7 (the mux drives an invalid control word).
- Grant logic is combinational from `req`, `reql` and the registered state. State is the round-robin pointer `ptr` (2 bits) and the starvation counters `cnt0` and `cnt1` (SCW bits each).
- Output reservation: output i is reserved when `STARVE_EN` is defined, `reql[i]` is high and `cnti == STARVE_MAX`.
- Ring allocation:
  - Scan ring requests starting at `ptr`, wrapping 3→0.
  - The first hit takes the lowest-numbered unreserved output; the second hit takes the remaining unreserved output.
  - At most 2 ring grants per cycle. Remaining ring requesters see `stall`.
- Local allocation: output i, if not taken by ring, goes to local i when `reql[i]` is high. Local i never uses output 1-i.
- Idle: an output with no grant gets `SEL_IDLE`.
- `ptr` update at posedge:
  - If any ring grant: ptr ← (last granted ring index + 1) mod 4.
  - Otherwise ptr holds.
- `cnti` update at posedge:
  - Cleared when `reql[i]` is low or `gntl[i]` is high.
  - Otherwise increments, saturating at `STARVE_MAX`.
- Reset (`rst` low), asynchronous and immediate:
  - ptr = 0, cnt0 = cnt1 = 0.
  - `gnt`, `gntl` and `stall` forced to 0; `sel0` = `sel1` = `SEL_IDLE`, regardless of requests.
  - Reset asserted mid-operation drops all in-progress grants in that cycle.

## Timing
- Grants and selects are valid in the same cycle as the requests (zero-latency Mealy). `mux4x2` registers its outputs, so a flit appears on `port*_co` one cycle after its grant.
- Handshake: a requester samples its grant at the posedge.
  - Granted: it advances to its next flit, or deasserts the request.
  - Not granted: it holds the request and data stable.
  - Back-to-back grants to the same port are allowed.
- State changes only at posedge or on asynchronous reset; there is no combinational path from `gnt` to `req`.
- Starvation bound: local i waits at most `STARVE_MAX`+1 cycles from request to grant.

## Configuration
- `MUX4X2_ARB_STARVE_EN` defined:
  - Counters and reservation are present.
  - Local injection is starvation-free.
- `MUX4X2_ARB_STARVE_EN` undefined:
  - Counters and reservation logic are removed.
  - Local i is granted only when output i is left unused by ring traffic; four persistent ring requesters can block injection indefinitely.
  - `STARVE_MAX` and `SCW` are ignored.

## Structure
- `defines.v` holds the `SEL_*` constants and `` `sel_w `` (3 bits).
- Sub-module `rr_pick4`: combinational first- and second-hit finder over a 4-bit vector from a 2-bit start pointer, with a 2-bit take-limit input. It is instantiated once.
- The top level holds the pointer and counter registers, reservation and local allocation, and the reset gating.

## Test plan
- **Reset:** `rst`=0 with req=4'b1111, reql=2'b11.
  - gnt=0, gntl=0, stall=0, sel0=sel1=7.
  - After release: ptr=0, first-cycle grants to ports 0 and 1.
- **Round-robin:** req=4'b1111 held 4 cycles.
  - sel0/sel1 sequence: (0,1), (2,3), (0,1), (2,3).
  - stall alternates 4'b1100 / 4'b0011.
- **Pointer wrap:** ptr=3, req=4'b1001.
  - sel0=3, sel1=0.
  - Next-cycle ptr=1.
- **Local fill:** req=4'b0100, reql=2'b11.
  - sel0=2, sel1=4, gntl=2'b10.
  - cnt0 increments.
- **Starvation (EN defined, STARVE_MAX=7):** req=4'b1111 and reql=2'b01 held.
  - On the 8th cycle, sel0=4 and gntl=2'b01, while sel1 carries one ring port.
  - cnt0 then clears.
  - With the macro undefined, gntl stays 0 for 20 cycles.
- **Async reset mid-stream:** drop `rst` between clock edges during the round-robin test.
  - Outputs go idle immediately.
  - After release, ptr restarts at 0.

Source files
------------

// File: rtl/mux4x2_arb_pkg.sv
// Shared constants and types for the hring 4x2 crossbar allocation controller.
// Select encoding matches what mux4x2 decodes on its sel0/sel1 inputs.
package mux4x2_arb_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_P0   = 3'd0;
    localparam logic [SEL_W-1:0] SEL_P1   = 3'd1;
    localparam logic [SEL_W-1:0] SEL_P2   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_P3   = 3'd3;
    localparam logic [SEL_W-1:0] SEL_LOC  = 3'd4;
    localparam logic [SEL_W-1:0] SEL_IDLE = 3'd7;

    typedef struct packed {
        logic [3:0]       gnt;
        logic [1:0]       gntl;
        logic [3:0]       stall;
        logic [SEL_W-1:0] sel0;
        logic [SEL_W-1:0] sel1;
    } arb_out_t;

    function automatic logic [SEL_W-1:0] sel_ring(input logic [1:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/mux4x2_arb_if.sv
// Request/grant bundle between the ring node requesters and mux4x2_arb.
interface mux4x2_arb_if;
    import mux4x2_arb_pkg::*;

    logic [3:0]       req;
    logic [1:0]       reql;
    logic [3:0]       gnt;
    logic [1:0]       gntl;
    logic [3:0]       stall;
    logic [SEL_W-1:0] sel0;
    logic [SEL_W-1:0] sel1;

    modport master (output req, reql, input gnt, gntl, stall, sel0, sel1);
    modport slave  (input req, reql, output gnt, gntl, stall, sel0, sel1);
endinterface

// File: rtl/mux4x2_arb_rr_pick4.sv
// First/second-hit finder over a 4-bit request vector, scanning from i_start
// and wrapping 3->0; i_limit (0..2) caps how many hits are reported.
module mux4x2_arb_rr_pick4 (
    input  logic [3:0] i_vec,
    input  logic [1:0] i_start,
    input  logic [1:0] i_limit,
    output logic       o_hit0,
    output logic [1:0] o_idx0,
    output logic       o_hit1,
    output logic [1:0] o_idx1
);
    always_comb begin
        logic [1:0] v_idx;
        v_idx  = 2'd0;
        o_hit0 = 1'b0;
        o_idx0 = 2'd0;
        o_hit1 = 1'b0;
        o_idx1 = 2'd0;
        for (int k = 0; k < 4; k++) begin
            v_idx = i_start + 2'(k);
            if (i_vec[v_idx]) begin
                if (!o_hit0 && i_limit != 2'd0) begin
                    o_hit0 = 1'b1;
                    o_idx0 = v_idx;
                end else if (o_hit0 && !o_hit1 && i_limit == 2'd2) begin
                    o_hit1 = 1'b1;
                    o_idx1 = v_idx;
                end
            end
        end
    end
endmodule

// File: rtl/mux4x2_arb.sv
// Allocation controller driving mux4x2 selects: round-robin ring grants plus
// local injection. Define MUX4X2_ARB_STARVE_EN to add the local starvation guard.
module mux4x2_arb #(
    parameter int STARVE_MAX = 7,
    parameter int SCW        = 3
) (
    input  logic        clk,
    input  logic        rst,
    mux4x2_arb_if.slave bus
);
    import mux4x2_arb_pkg::*;

    if (STARVE_MAX < 1 || STARVE_MAX >= (1 << SCW)) begin : g_bad_cfg
        $error("mux4x2_arb: SCW too narrow for STARVE_MAX");
    end

    logic [1:0] r_ptr;
    logic [1:0] w_res;
    logic [1:0] w_limit;
    logic       w_hit0, w_hit1;
    logic [1:0] w_idx0, w_idx1;
    arb_out_t   w_out;

`ifdef MUX4X2_ARB_STARVE_EN
    localparam logic [SCW-1:0] SMAX = SCW'(STARVE_MAX);
    logic [SCW-1:0] r_cnt0, r_cnt1;

    // A starved local port reserves its own output ahead of ring traffic.
    assign w_res = {bus.reql[1] && (r_cnt1 == SMAX), bus.reql[0] && (r_cnt0 == SMAX)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (!bus.reql[0] || w_out.gntl[0]) r_cnt0 <= '0;
            else if (r_cnt0 != SMAX)           r_cnt0 <= r_cnt0 + SCW'(1);
            if (!bus.reql[1] || w_out.gntl[1]) r_cnt1 <= '0;
            else if (r_cnt1 != SMAX)           r_cnt1 <= r_cnt1 + SCW'(1);
        end
    end
`else
    assign w_res = 2'b00;
`endif

    assign w_limit = {1'b0, ~w_res[0]} + {1'b0, ~w_res[1]};

    mux4x2_arb_rr_pick4 u_pick (
        .i_vec   (bus.req),
        .i_start (r_ptr),
        .i_limit (w_limit),
        .o_hit0  (w_hit0),
        .o_idx0  (w_idx0),
        .o_hit1  (w_hit1),
        .o_idx1  (w_idx1)
    );

    always_comb begin
        w_out = '{gnt: 4'b0, gntl: 2'b0, stall: 4'b0, sel0: SEL_IDLE, sel1: SEL_IDLE};
        if (w_hit0) begin
            w_out.gnt[w_idx0] = 1'b1;
            if (!w_res[0]) w_out.sel0 = sel_ring(w_idx0);
            else           w_out.sel1 = sel_ring(w_idx0);
        end
        if (w_hit1) begin
            w_out.gnt[w_idx1] = 1'b1;
            w_out.sel1        = sel_ring(w_idx1);
        end
        // Local i only ever fills its own output, and only if ring left it idle.
        if (w_out.sel0 == SEL_IDLE && bus.reql[0]) begin
            w_out.sel0    = SEL_LOC;
            w_out.gntl[0] = 1'b1;
        end
        if (w_out.sel1 == SEL_IDLE && bus.reql[1]) begin
            w_out.sel1    = SEL_LOC;
            w_out.gntl[1] = 1'b1;
        end
        w_out.stall = bus.req & ~w_out.gnt;
        if (!rst) w_out = '{gnt: 4'b0, gntl: 2'b0, stall: 4'b0, sel0: SEL_IDLE, sel1: SEL_IDLE};
    end

    assign bus.gnt   = w_out.gnt;
    assign bus.gntl  = w_out.gntl;
    assign bus.stall = w_out.stall;
    assign bus.sel0  = w_out.sel0;
    assign bus.sel1  = w_out.sel1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_ptr <= 2'd0;
        else if (w_hit0) r_ptr <= (w_hit1 ? w_idx1 : w_idx0) + 2'd1;
    end
endmodule

// File: tb/tb_mux4x2_arb.sv
// Directed vector bench for mux4x2_arb: table of single-cycle vectors run from
// reset, then starvation and asynchronous-reset sequences.
module tb_mux4x2_arb;
    import mux4x2_arb_pkg::*;

    typedef struct {
        logic [3:0] req;
        logic [1:0] reql;
        logic [3:0] gnt;
        logic [1:0] gntl;
        logic [3:0] stall;
        logic [2:0] sel0;
        logic [2:0] sel1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl [13];

    mux4x2_arb_if bus ();

    mux4x2_arb #(.STARVE_MAX(7), .SCW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] g, input logic [1:0] gl,
                         input logic [3:0] st, input logic [2:0] s0, input logic [2:0] s1);
        n_vec++;
        if ({bus.gnt, bus.gntl, bus.stall, bus.sel0, bus.sel1} !== {g, gl, st, s0, s1}) begin
            n_err++;
            $display("FAIL %s: got gnt=%b gntl=%b stall=%b sel0=%0d sel1=%0d, want gnt=%b gntl=%b stall=%b sel0=%0d sel1=%0d",
                     name, bus.gnt, bus.gntl, bus.stall, bus.sel0, bus.sel1, g, gl, st, s0, s1);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [1:0] rl);
        @(negedge clk);
        bus.req  = r;
        bus.reql = rl;
        #2;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 2'b11, 4'b0011, 2'b00, 4'b1100, 3'd0, 3'd1};
        tbl[1]  = '{4'b1111, 2'b00, 4'b1100, 2'b00, 4'b0011, 3'd2, 3'd3};
        tbl[2]  = '{4'b1111, 2'b00, 4'b0011, 2'b00, 4'b1100, 3'd0, 3'd1};
        tbl[3]  = '{4'b1111, 2'b00, 4'b1100, 2'b00, 4'b0011, 3'd2, 3'd3};
        tbl[4]  = '{4'b0100, 2'b00, 4'b0100, 2'b00, 4'b0000, 3'd2, 3'd7};
        tbl[5]  = '{4'b1001, 2'b00, 4'b1001, 2'b00, 4'b0000, 3'd3, 3'd0};
        tbl[6]  = '{4'b0011, 2'b00, 4'b0011, 2'b00, 4'b0000, 3'd1, 3'd0};
        tbl[7]  = '{4'b0100, 2'b11, 4'b0100, 2'b10, 4'b0000, 3'd2, 3'd4};
        tbl[8]  = '{4'b0000, 2'b01, 4'b0000, 2'b01, 4'b0000, 3'd4, 3'd7};
        tbl[9]  = '{4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 3'd7, 3'd7};
        tbl[10] = '{4'b1000, 2'b10, 4'b1000, 2'b10, 4'b0000, 3'd3, 3'd4};
        tbl[11] = '{4'b0001, 2'b11, 4'b0001, 2'b10, 4'b0000, 3'd0, 3'd4};
        tbl[12] = '{4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 3'd7, 3'd7};

        bus.req  = 4'b1111;
        bus.reql = 2'b11;
        #3;
        check("reset_hold", 4'b0000, 2'b00, 4'b0000, SEL_IDLE, SEL_IDLE);
        @(negedge clk);
        @(negedge clk);
        bus.req  = 4'b0000;
        bus.reql = 2'b00;
        rst      = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].req, tbl[i].reql);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].gntl, tbl[i].stall, tbl[i].sel0, tbl[i].sel1);
        end

        // ptr is now 1 and both counters are clear.
`ifdef MUX4X2_ARB_STARVE_EN
        for (int c = 1; c <= 9; c++) begin
            drive(4'b1111, 2'b01);
            if (c == 8)      check("starve_grant", 4'b1000, 2'b01, 4'b0111, SEL_LOC, 3'd3);
            else if (c == 9) check("starve_clear", 4'b0011, 2'b00, 4'b1100, 3'd0, 3'd1);
            else if (c % 2)  check($sformatf("starve_wait%0d", c), 4'b0110, 2'b00, 4'b1001, 3'd1, 3'd2);
            else             check($sformatf("starve_wait%0d", c), 4'b1001, 2'b00, 4'b0110, 3'd3, 3'd0);
        end
        drive(4'b1111, 2'b00);
        check("pre_async", 4'b1100, 2'b00, 4'b0011, 3'd2, 3'd3);
`else
        for (int c = 1; c <= 20; c++) begin
            drive(4'b1111, 2'b01);
            if (c % 2) check($sformatf("block_local%0d", c), 4'b0110, 2'b00, 4'b1001, 3'd1, 3'd2);
            else       check($sformatf("block_local%0d", c), 4'b1001, 2'b00, 4'b0110, 3'd3, 3'd0);
        end
        drive(4'b1111, 2'b00);
        check("pre_async", 4'b0110, 2'b00, 4'b1001, 3'd1, 3'd2);
`endif

        #1;
        rst = 1'b0;
        #1;
        check("async_idle", 4'b0000, 2'b00, 4'b0000, SEL_IDLE, SEL_IDLE);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("post_reset_ptr0", 4'b0011, 2'b00, 4'b1100, 3'd0, 3'd1);
        drive(4'b1111, 2'b00);
        check("post_reset_next", 4'b1100, 2'b00, 4'b0011, 3'd2, 3'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
